chip8_timers: RTL and testbench
===============================

Name: chip8_timers

Overview:
- CHIP-8 delay timer (DT) and sound timer (ST), decremented at 60 Hz from the single system clock.
- Sits between the divided-clock generator and the CPU/audio output.
- Consumes the system clock and produces a one-cycle 60 Hz tick strobe rather than a divided clock, so all logic stays in one clock domain.
- Serves the CPU's Fx15/Fx18/Fx07 accesses and drives a square-wave buzzer.

Parameters:
- CLK_HZ, 1_000_000, frequency of clk_in in Hz
- TICK_HZ, 60, timer decrement rate; TICK_DIV = CLK_HZ/TICK_HZ (integer, ≥2, elaborate-time check)
- TONE_HZ, 440, buzzer square-wave frequency; TONE_HALF = CLK_HZ/(2*TONE_HZ) (integer, ≥1, elaborate-time check)

Ports:
- clk_in  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- pause  input  1  high: freeze tick counter, timers and tone phase
- wr_en  input  1  one-cycle write strobe from CPU
- wr_sel  input  1  0 = DT, 1 = ST
- wr_data  input  8  value to load
- dt_value  output  8  current DT (registered)
- st_value  output  8  current ST (registered)
- tick  output  1  one-cycle strobe at TICK_HZ
- beep  output  1  high while ST != 0
- tone  output  1  square wave at TONE_HZ while beep, else 0

Behaviour:
- Reset (rst low, asynchronous):
  - tick_cnt=0, dt=0, st=0, tone_cnt=0, tone=0, tick=0.
  - beep=0 follows from st=0.
  - All state leaves reset on the first clk_in edge after rst rises.
- Tick generator:
  - tick_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick is registered: high for exactly the cycle after tick_cnt==TICK_DIV-1, i.e. one pulse every TICK_DIV cycles.
  - First pulse occurs TICK_DIV cycles after reset release.
  - With pause=1: tick_cnt holds and tick=0; the count resumes from the held value.
- Timers (each evaluated independently per cycle, priority in this order):
  1. wr_en and wr_sel selects this timer: load wr_data. The write wins over a same-cycle tick; the loaded value is not decremented that cycle.
  2. tick and value != 0: decrement by 1.
  3. Otherwise hold. Timers saturate at 0 and never wrap to 255.
- A write to DT in the same cycle as a tick still lets ST decrement, and vice versa.
- Writes are accepted while paused (CPU-initiated).
- dt_value/st_value reflect a write one cycle after the wr_en edge (registered), consistent for a CPU read in the next cycle.
- beep = (st != 0), taken combinationally from the st register.
- Tone generator:
  - While beep and !pause: tone_cnt counts 0..TONE_HALF-1; tone toggles when tone_cnt==TONE_HALF-1, then tone_cnt wraps to 0.
  - When beep=0: tone_cnt=0 and tone=0 in the next cycle, so every beep starts with a low phase of TONE_HALF cycles.
  - pause holds tone_cnt and tone.
- Reset mid-operation clears everything immediately; no partial tick or decrement is issued.
- Widths: counters are sized $clog2(TICK_DIV) and $clog2(TONE_HALF)+1; timer arithmetic is 8-bit unsigned.

Decomposition:
- Shared package chip8_pkg holds:
  - TIMER_W=8
  - TIMER_SEL_DT=1'b0 and TIMER_SEL_ST=1'b1
  - CLK_HZ default constant, shared with the divider and the CPU
- One sub-module, tick_gen:
  - Parameter DIV; ports clk_in, rst, en, tick.
  - Used for the 60 Hz strobe.
  - The tone toggle uses its own counter inline because of its beep-gated clear.

Test Plan (CLK_HZ=600, TICK_HZ=60 → TICK_DIV=10; TONE_HZ=150 → TONE_HALF=2):
- Reset release, idle 40 cycles -> tick pulses at cycles 10, 20, 30, 40, each 1 cycle wide; dt=st=0; beep=0; tone=0.
- Write DT=3 at cycle 2 -> dt_value=3 at cycle 3, then 2, 1, 0 after the ticks at 10, 20, 30; stays 0 after tick 40 (no wrap to 255).
- Write ST=2 in the same cycle as a tick -> st_value=2 (no decrement), then 1 at the next tick and 0 at the one after. beep high exactly while st!=0; tone shows period 4 starting low; tone=0 one cycle after beep falls.
- DT=5 and ST=5; write DT=9 on a tick cycle -> dt=9, st=4.
- pause=1 for 25 cycles mid-count with DT=2 -> no tick, dt holds, tone frozen. After release, the next tick arrives after the remaining counts only (held tick_cnt value preserved).
- Assert rst mid-beep (ST=7, tone high) -> st, dt, tone, beep and tick go to 0 asynchronously, without waiting for a clock edge. After release, the first tick comes 10 cycles later.

Source files
------------

// File: rtl/chip8_pkg.sv
// chip8_pkg: constants shared by the CHIP-8 timers, clock divider and CPU.
package chip8_pkg;
    localparam int   TIMER_W      = 8;
    localparam logic TIMER_SEL_DT = 1'b0;
    localparam logic TIMER_SEL_ST = 1'b1;
    localparam int   CLK_HZ       = 1_000_000;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-cycle strobe every DIV enabled cycles; disabling holds the count.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk_in,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] tick_cnt;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick     <= en && tick_cnt == LAST;
            tick_cnt <= !en ? tick_cnt : tick_cnt == LAST ? '0 : tick_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/chip8_timers.sv
// chip8_timers: CHIP-8 delay/sound timers decremented at TICK_HZ, with a
// square-wave buzzer that runs while the sound timer is non-zero.
module chip8_timers
    import chip8_pkg::*;
#(
    parameter int CLK_HZ  = chip8_pkg::CLK_HZ,
    parameter int TICK_HZ = 60,
    parameter int TONE_HZ = 440
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               pause,
    input  logic               wr_en,
    input  logic               wr_sel,
    input  logic [TIMER_W-1:0] wr_data,
    output logic [TIMER_W-1:0] dt_value,
    output logic [TIMER_W-1:0] st_value,
    output logic               tick,
    output logic               beep,
    output logic               tone
);
    localparam int TICK_DIV  = CLK_HZ / TICK_HZ;
    localparam int TONE_HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int TW        = $clog2(TONE_HALF) + 1;
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

    if (TICK_DIV < 2 || CLK_HZ % TICK_HZ != 0) begin : g_bad_tick
        $error("chip8_timers: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if (TONE_HALF < 1 || CLK_HZ % (2 * TONE_HZ) != 0) begin : g_bad_tone
        $error("chip8_timers: CLK_HZ/(2*TONE_HZ) must be an integer >= 1");
    end

    logic               run_tick;
    logic [TIMER_W-1:0] dt_nxt;
    logic [TIMER_W-1:0] st_nxt;
    logic [TW-1:0]      tone_cnt;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (!pause),
        .tick   (tick)
    );

    assign beep = st_value != '0;

    // A tick already in flight when pause rises must not decrement.
    always_comb begin
        run_tick = tick && !pause;
        dt_nxt   = (wr_en && wr_sel == TIMER_SEL_DT) ? wr_data :
                   (run_tick && dt_value != '0) ? dt_value - 1'b1 : dt_value;
        st_nxt   = (wr_en && wr_sel == TIMER_SEL_ST) ? wr_data :
                   (run_tick && st_value != '0) ? st_value - 1'b1 : st_value;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            dt_value <= '0;
            st_value <= '0;
        end else begin
            dt_value <= dt_nxt;
            st_value <= st_nxt;
        end
    end

    // Clearing on !beep makes every beep start with a full low half-period.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (!beep) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (!pause) begin
            tone_cnt <= tone_cnt == TONE_LAST ? '0 : tone_cnt + 1'b1;
            tone     <= tone_cnt == TONE_LAST ? ~tone : tone;
        end
    end
endmodule

// File: tb/tb_chip8_timers.sv
// tb_chip8_timers: directed checks of tick timing, timer load/decrement,
// pause freeze, buzzer phase and asynchronous reset (TICK_DIV=10, TONE_HALF=2).
module tb_chip8_timers;
    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       pause = 1'b0;
    logic       wr_en = 1'b0;
    logic       wr_sel = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic [7:0] dt_value;
    logic [7:0] st_value;
    logic       tick;
    logic       beep;
    logic       tone;
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    chip8_timers #(.CLK_HZ(600), .TICK_HZ(60), .TONE_HZ(150)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .pause    (pause),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .dt_value (dt_value),
        .st_value (st_value),
        .tick     (tick),
        .beep     (beep),
        .tone     (tone)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Each step lands 1 time unit after a rising edge, so cyc numbers the cycle.
    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic write(input logic sel, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = d;
    endtask

    initial begin
        #3;
        chk("rst_dt", dt_value, 8'd0);
        chk("rst_st", st_value, 8'd0);
        chk("rst_tick", {7'd0, tick}, 8'd0);
        chk("rst_beep", {7'd0, beep}, 8'd0);
        chk("rst_tone", {7'd0, tone}, 8'd0);
        #19 rst = 1'b1;
        // DT=3 written at cycle 2, counts down on ticks 10/20/30, saturates at 0
        step();
        step();
        write(1'b0, 8'd3);
        step();
        wr_en = 1'b0;
        chk("a_dt_load", dt_value, 8'd3);
        while (cyc < 42) begin
            step();
            chk("a_tick", {7'd0, tick}, {7'd0, cyc % 10 == 0});
            chk("a_dt", dt_value, cyc < 11 ? 8'd3 : cyc < 21 ? 8'd2 : cyc < 31 ? 8'd1 : 8'd0);
            chk("a_st", st_value, 8'd0);
            chk("a_beep", {7'd0, beep}, 8'd0);
            chk("a_tone", {7'd0, tone}, 8'd0);
        end
        // ST=2 written on the tick at cycle 50: load wins, then 1 and 0
        while (cyc < 50) step();
        chk("b_tick50", {7'd0, tick}, 8'd1);
        write(1'b1, 8'd2);
        step();
        wr_en = 1'b0;
        repeat (21) begin
            chk("b_st", st_value, cyc < 61 ? 8'd2 : cyc < 71 ? 8'd1 : 8'd0);
            chk("b_beep", {7'd0, beep}, {7'd0, cyc < 71});
            chk("b_tone", {7'd0, tone}, {7'd0, cyc < 71 && (((cyc - 51) >> 1) & 1) == 1});
            chk("b_tick", {7'd0, tick}, {7'd0, cyc == 60 || cyc == 70});
            step();
        end
        chk("b_tone_off", {7'd0, tone}, 8'd0);
        // DT=5, ST=5, then DT=9 on the tick at 80: DT loads, ST still decrements
        write(1'b0, 8'd5);
        step();
        write(1'b1, 8'd5);
        step();
        wr_en = 1'b0;
        step();
        chk("c_dt5", dt_value, 8'd5);
        chk("c_st5", st_value, 8'd5);
        while (cyc < 80) step();
        chk("c_tick80", {7'd0, tick}, 8'd1);
        write(1'b0, 8'd9);
        step();
        wr_en = 1'b0;
        chk("c_dt9", dt_value, 8'd9);
        chk("c_st4", st_value, 8'd4);
        // DT=2, pause cycles 85..109 with tick_cnt=5 held; next tick at 115
        write(1'b0, 8'd2);
        step();
        wr_en = 1'b0;
        chk("d_dt2", dt_value, 8'd2);
        while (cyc < 85) step();
        chk("d_tone85", {7'd0, tone}, 8'd1);
        pause = 1'b1;
        while (cyc < 110) begin
            step();
            chk("d_p_tick", {7'd0, tick}, 8'd0);
            chk("d_p_dt", dt_value, 8'd2);
            chk("d_p_st", st_value, 8'd4);
            chk("d_p_tone", {7'd0, tone}, 8'd1);
        end
        pause = 1'b0;
        step();
        chk("d_tone_resume", {7'd0, tone}, 8'd0);
        while (cyc < 115) begin
            step();
            chk("d_tick", {7'd0, tick}, {7'd0, cyc == 115});
        end
        step();
        chk("d_dt1", dt_value, 8'd1);
        chk("d_st3", st_value, 8'd3);
        // ST=7 with tone high, then asynchronous reset between edges
        write(1'b1, 8'd7);
        step();
        wr_en = 1'b0;
        chk("e_st7", st_value, 8'd7);
        chk("e_tone_hi", {7'd0, tone}, 8'd1);
        chk("e_beep_hi", {7'd0, beep}, 8'd1);
        #2 rst = 1'b0;
        #1;
        chk("e_rst_dt", dt_value, 8'd0);
        chk("e_rst_st", st_value, 8'd0);
        chk("e_rst_tone", {7'd0, tone}, 8'd0);
        chk("e_rst_beep", {7'd0, beep}, 8'd0);
        chk("e_rst_tick", {7'd0, tick}, 8'd0);
        #3 rst = 1'b1;
        cyc = 0;
        while (cyc < 11) begin
            step();
            chk("e_tick", {7'd0, tick}, {7'd0, cyc == 10});
            chk("e_dt", dt_value, 8'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
